// File: rtl/alu32_gate_sequencer_pkg.sv
// Shared definitions for the ALU32 gate-cluster sequencer: opcodes, FSM encoding
// and the opcode legality helper.
package alu32_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_OR  = 3'd0;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_NOR = 3'd3;
   localparam logic [2:0] OP_ADD = 3'd4;
   localparam logic [2:0] OP_SUB = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_SUB);
   endfunction

endpackage

// File: rtl/alu32_gate_sequencer_result_mux.sv
// Combinational select of the external gate-unit outputs by opcode.
// Illegal opcodes yield zero data and no carry.
module alu32_result_mux
   import alu32_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] or_res_i,
   input  logic [WIDTH-1:0] and_res_i,
   input  logic [WIDTH-1:0] xor_res_i,
   input  logic [WIDTH-1:0] add_res_i,
   input  logic             add_cout_i,
   output logic [WIDTH-1:0] data_o,
   output logic             carry_o
);

   always_comb begin
      data_o  = '0;
      carry_o = 1'b0;
      case (op_i)
         OP_OR:  data_o = or_res_i;
         OP_AND: data_o = and_res_i;
         OP_XOR: data_o = xor_res_i;
         OP_NOR: data_o = ~or_res_i;
         OP_ADD, OP_SUB: begin
            data_o  = add_res_i;
            carry_o = add_cout_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu32_gate_sequencer.sv
// Sequencer around the external OR/AND/XOR/ADD gate cluster: accepts a request,
// holds operands for SETTLE_CYCLES, captures the selected result, returns it.
module alu32_gate_sequencer
   import alu32_pkg::*;
#(
   parameter int WIDTH         = DATA_W,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [2:0]       ReqOp,
   input  logic [WIDTH-1:0] ReqA,
   input  logic [WIDTH-1:0] ReqB,
   output logic [WIDTH-1:0] GateIn1,
   output logic [WIDTH-1:0] GateIn2,
   output logic             GateCin,
   input  logic [WIDTH-1:0] OrRes,
   input  logic [WIDTH-1:0] AndRes,
   input  logic [WIDTH-1:0] XorRes,
   input  logic [WIDTH-1:0] AddRes,
   input  logic             AddCout,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [WIDTH-1:0] RspData,
   output logic             RspZero,
   output logic             RspCarry,
   output logic             RspErr,
   output logic [1:0]       DbgState
);

   // Both sides use valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; a producer holds valid and payload until then.

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] gate_in1_q, gate_in2_q;
   logic             gate_cin_q;
   logic [WIDTH-1:0] data_q;
   logic             zero_q, carry_q, err_q;
   logic [WIDTH-1:0] mux_data;
   logic             mux_carry;
   logic             accept, capture;

   assign accept  = ReqValid && (state_q == ST_IDLE);
   assign capture = (state_q == ST_SETTLE) && (cnt_q == 4'd0);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (ReqValid) begin
               if (op_legal(ReqOp)) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd0) state_d = ST_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_DONE: begin
            if (RspReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ReqReady = (state_q == ST_IDLE);
      RspValid = (state_q == ST_DONE);
      DbgState = state_q;
   end

   alu32_result_mux #(.WIDTH(WIDTH)) u_mux (
      .op_i       (op_q),
      .or_res_i   (OrRes),
      .and_res_i  (AndRes),
      .xor_res_i  (XorRes),
      .add_res_i  (AddRes),
      .add_cout_i (AddCout),
      .data_o     (mux_data),
      .carry_o    (mux_carry)
   );

   // Illegal ops bypass SETTLE, so their error response is loaded at accept time.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         op_q       <= OP_OR;
         gate_in1_q <= '0;
         gate_in2_q <= '0;
         gate_cin_q <= 1'b0;
         data_q     <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         err_q      <= 1'b0;
      end else if (accept) begin
         op_q       <= ReqOp;
         gate_in1_q <= ReqA;
         gate_in2_q <= (ReqOp == OP_SUB) ? ~ReqB : ReqB;
         gate_cin_q <= (ReqOp == OP_SUB);
         if (!op_legal(ReqOp)) begin
            data_q  <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
         end
      end else if (capture) begin
         data_q  <= mux_data;
         zero_q  <= (mux_data == '0);
         carry_q <= mux_carry;
         err_q   <= 1'b0;
      end
   end

   assign GateIn1  = gate_in1_q;
   assign GateIn2  = gate_in2_q;
   assign GateCin  = gate_cin_q;
   assign RspData  = data_q;
   assign RspZero  = zero_q;
   assign RspCarry = carry_q;
   assign RspErr   = err_q;

endmodule
